tnn_feature_encoder: RTL and testbench

- Front-end producer for the 2-bit-per-feature TNN classifiers (5 features × 2 bits, 1-bit class output).
- Accepts a stream of raw unsigned feature samples and quantizes each to 2 bits against per-feature thresholds.
- Packs each 5-sample frame into the 10-bit vector the classifier consumes and holds it under a valid/ready handshake.
- Detects frame-boundary errors and resynchronizes on them.

---
 rtl/tnn_feature_encoder.sv | 107 ++++++++++
 tb/tb_tnn_feature_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_encoder.sv
// Quantizes a stream of raw feature samples to 2 bits each and packs each
// NUM_FEAT-sample frame into a vector held under a valid/ready handshake.
module tnn_feature_encoder #(
  parameter int NUM_FEAT = 5,
  parameter int RAW_W    = 8,
  parameter logic [NUM_FEAT*3*RAW_W-1:0] THRESH = {5{8'd192, 8'd128, 8'd64}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [RAW_W-1:0]      s_data,
  input  logic                  s_last,
  output logic                  feat_valid,
  input  logic                  feat_ready,
  output logic [2*NUM_FEAT-1:0] feat_vec,
  output logic                  frame_err,
  output logic [7:0]            err_count
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {COLLECT, RESYNC, HOLD} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [2*NUM_FEAT-1:0]   work;
  logic [2*NUM_FEAT-1:0]   work_nxt;
  logic [1:0]              q;
  logic [RAW_W-1:0]        thr;
  logic                    accept;

  // Count of thresholds met, so the three thresholds may be in any order.
  always_comb begin
    q   = '0;
    thr = '0;
    for (int unsigned j = 0; j < 3; j++) begin
      thr = THRESH[(3 * 32'(idx) + j) * RAW_W +: RAW_W];
      if (s_data >= thr) q = q + 2'd1;
    end
  end

  always_comb begin
    work_nxt = work;
    work_nxt[2 * 32'(idx) +: 2] = q;
  end

  assign accept = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      idx        <= '0;
      work       <= '0;
      feat_vec   <= '0;
      feat_valid <= 1'b0;
      s_ready    <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          s_ready <= 1'b1;
          if (accept) begin
            work <= work_nxt;
            if (s_last && idx == LAST_IDX) begin
              feat_vec   <= work_nxt;
              feat_valid <= 1'b1;
              s_ready    <= 1'b0;
              idx        <= '0;
              state      <= HOLD;
            end else if (s_last || idx == LAST_IDX) begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              idx <= '0;
              if (!s_last) state <= RESYNC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RESYNC: begin
          s_ready <= 1'b1;
          if (accept && s_last) begin
            idx   <= '0;
            state <= COLLECT;
          end
        end
        HOLD: begin
          if (feat_ready) begin
            feat_valid <= 1'b0;
            s_ready    <= 1'b1;
            state      <= COLLECT;
          end
        end
        default: begin
          state   <= COLLECT;
          idx     <= '0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_feature_encoder.sv
// Bench for tnn_feature_encoder: directed and random frames against a
// frame-level reference model, on default and custom-threshold instances.
module tb_tnn_feature_encoder;

  localparam int NF = 5;
  localparam int RW = 8;
  localparam logic [NF*3*RW-1:0] THR2 = {8'd192, 8'd128, 8'd64,
                                         8'd192, 8'd128, 8'd64,
                                         8'd192, 8'd128, 8'd64,
                                         8'd100, 8'd50,  8'd200,
                                         24'h000000};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_last;
  logic          feat_ready;
  logic [RW-1:0] s_data;

  logic          rdy  [2];
  logic          fv   [2];
  logic [9:0]    vec  [2];
  logic          ferr [2];
  logic [7:0]    ecnt [2];

  int errors = 0;
  int checks = 0;

  int thr [2][NF][3];
  int frame[$];
  bit m_resync, m_hold, m_rdy, m_err_pulse;
  int m_vec [2];
  int m_ecnt;

  always #5 clk = ~clk;

  tnn_feature_encoder #(.NUM_FEAT(NF), .RAW_W(RW)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy[0]),
    .s_data(s_data), .s_last(s_last), .feat_valid(fv[0]),
    .feat_ready(feat_ready), .feat_vec(vec[0]), .frame_err(ferr[0]),
    .err_count(ecnt[0]));

  tnn_feature_encoder #(.NUM_FEAT(NF), .RAW_W(RW), .THRESH(THR2)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy[1]),
    .s_data(s_data), .s_last(s_last), .feat_valid(fv[1]),
    .feat_ready(feat_ready), .feat_vec(vec[1]), .frame_err(ferr[1]),
    .err_count(ecnt[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int quant(input int d, input int f, input int raw);
    int n = 0;
    for (int j = 0; j < 3; j++)
      if (raw >= thr[d][f][j]) n++;
    return n;
  endfunction

  function automatic int pack(input int d);
    int v = 0;
    for (int f = 0; f < NF; f++)
      v += quant(d, f, frame[f]) << (2 * f);
    return v;
  endfunction

  task automatic model_reset();
    frame.delete();
    m_resync = 0; m_hold = 0; m_rdy = 0; m_err_pulse = 0;
    m_vec[0] = 0; m_vec[1] = 0; m_ecnt = 0;
  endtask

  task automatic model_edge();
    m_err_pulse = 0;
    if (m_hold) begin
      if (feat_ready) m_hold = 0;
    end else if (m_rdy && s_valid) begin
      if (m_resync) begin
        if (s_last) m_resync = 0;
      end else begin
        frame.push_back(int'(s_data));
        if (s_last && frame.size() == NF) begin
          m_vec[0] = pack(0);
          m_vec[1] = pack(1);
          m_hold = 1;
          frame.delete();
        end else if (s_last || frame.size() == NF) begin
          m_err_pulse = 1;
          if (m_ecnt < 255) m_ecnt++;
          if (!s_last) m_resync = 1;
          frame.delete();
        end
      end
    end
    m_rdy = !m_hold;
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s_ready%0d", d),    32'(rdy[d]),  32'(m_rdy));
      chk($sformatf("feat_valid%0d", d), 32'(fv[d]),   32'(m_hold));
      chk($sformatf("feat_vec%0d", d),   32'(vec[d]),  32'(m_vec[d]));
      chk($sformatf("frame_err%0d", d),  32'(ferr[d]), 32'(m_err_pulse));
      chk($sformatf("err_count%0d", d),  32'(ecnt[d]), 32'(m_ecnt));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic put(input int d, input bit last);
    s_valid = 1'b1;
    s_data  = RW'(d);
    s_last  = last;
    step();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
  endtask

  initial begin
    int pat [5] = '{10, 64, 100, 191, 255};
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < NF; f++)
        for (int j = 0; j < 3; j++)
          thr[d][f][j] = 64 * (j + 1);
    thr[1][0][0] = 0;   thr[1][0][1] = 0;  thr[1][0][2] = 0;
    thr[1][1][0] = 200; thr[1][1][1] = 50; thr[1][1][2] = 100;

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; feat_ready = 1'b1;
    model_reset();
    #2;
    compare();
    @(posedge clk); #1;
    rst_n = 1'b1;
    compare();
    idle();

    // Golden frame with immediate handoff.
    for (int i = 0; i < 5; i++) put(pat[i], i == 4);
    chk("golden_vec", 32'(vec[0]), 32'(10'b11_10_01_01_00));
    chk("golden_valid", 32'(fv[0]), 32'd1);
    idle();
    chk("bubble_ready", 32'(rdy[0]), 32'd1);

    // Backpressure: held for 6 cycles while samples are offered.
    feat_ready = 1'b0;
    for (int i = 0; i < 5; i++) put(pat[i], i == 4);
    for (int i = 0; i < 6; i++) put(int'($urandom_range(0, 255)), 1'b1);
    chk("hold_vec", 32'(vec[0]), 32'(10'b11_10_01_01_00));
    s_valid = 1'b0; feat_ready = 1'b1;
    step();
    chk("hold_release", 32'(fv[0]), 32'd0);
    idle();

    // Short frame, then a clean frame.
    for (int i = 0; i < 3; i++) put(pat[i], i == 2);
    chk("short_err", 32'(ferr[0]), 32'd1);
    idle();
    for (int i = 0; i < 5; i++) put(pat[4 - i], i == 4);
    idle();

    // Long frame of 7, then a clean frame.
    for (int i = 0; i < 7; i++) put(i * 37, i == 6);
    for (int i = 0; i < 5; i++) put(pat[i], i == 4);
    chk("long_recover", 32'(vec[0]), 32'(10'b11_10_01_01_00));
    idle();

    // Custom thresholds: zero thresholds and unordered thresholds.
    put(0, 0); put(120, 0); put(0, 0); put(0, 0); put(0, 1);
    chk("thr_custom", 32'(vec[1][3:0]), 32'(4'b10_11));
    idle();

    // Reset mid-frame.
    for (int i = 0; i < 3; i++) put(pat[i], 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b0;
    compare();
    idle();
    for (int i = 0; i < 5; i++) put(pat[i], i == 4);
    idle();

    // Random traffic biased toward well-formed frames.
    for (int n = 0; n < 500; n++) begin
      bit last;
      feat_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) last = (frame.size() == NF - 1);
      else last = ($urandom_range(0, 1) == 1);
      s_valid = ($urandom_range(0, 4) != 0);
      s_data  = RW'($urandom_range(0, 255));
      s_last  = last;
      step();
    end
    feat_ready = 1'b1;
    idle();
    idle();

    // Saturation of the error counter.
    for (int n = 0; n < 300; n++) put(int'($urandom_range(0, 255)), 1'b1);
    chk("err_sat", 32'(ecnt[0]), 32'd255);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
